// File: rtl/phase_step_controller.sv
// Purpose: decode the six-phase one-hot bus into registered per-stage enable strobes.
// Latency: 1 cycle from the sampled phase edge to its strobe; all outputs registered.
// Backpressure: MemReady=0 at Phases[3] stalls in WAIT_MEM (bounded by MAX_WAIT); Halt parks in HALTED.
//
// Ports:
//   inClk, Reset          clock and async active-high reset
//   Phases[5:0]           one-hot phase bus from the phase generator
//   MemReady              memory access done, looked at only on Phases[3]
//   Halt                  halt request, looked at on Phases[5] (enter) and Phases[0] (exit)
//   IrLdEn..PcWrEn        stage strobes for phases 0..5
//   Busy                  RUN or WAIT_MEM
//   PhaseErr, MemTimeout  sticky error flags, cleared only by Reset
//   InstrCount            retired instructions, wraps silently
//
// Build option: define PHASE_CHECK_EN to track the expected phase and trap any
// out-of-sequence, missing or multi-hot phase into ERROR with PhaseErr set.
module phase_step_controller #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             inClk,
  input  logic             Reset,
  input  logic [5:0]       Phases,
  input  logic             MemReady,
  input  logic             Halt,
  output logic             IrLdEn,
  output logic             RegRdEn,
  output logic             AluEn,
  output logic             MemEn,
  output logic             RegWrEn,
  output logic             PcWrEn,
  output logic             Busy,
  output logic             PhaseErr,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    WAIT_MEM = 3'd2,
    HALTED   = 3'd3,
    ERROR    = 3'd4
  } state_t;

  localparam logic [8:0] MAX_WAIT_C = 9'(MAX_WAIT);

  state_t           state, state_nxt;
  logic [7:0]       waitcnt, waitcnt_nxt;
  logic [8:0]       waitcnt_inc;
  logic [5:0]       strobe, strobe_nxt;
  logic             busy_q, busy_nxt;
  logic             memtimeout_q, memtimeout_nxt;
  logic [CNT_W-1:0] count, count_nxt;

`ifdef PHASE_CHECK_EN
  logic [2:0]       expphase, expphase_nxt;
  logic             phaseerr_q, phaseerr_nxt;
`endif

  // one wider so the compare against MAX_WAIT=255 cannot wrap
  assign waitcnt_inc = {1'b0, waitcnt} + 9'd1;

  always_comb begin
    state_nxt      = state;
    waitcnt_nxt    = waitcnt;
    strobe_nxt     = '0;
    count_nxt      = count;
    memtimeout_nxt = memtimeout_q;
`ifdef PHASE_CHECK_EN
    expphase_nxt   = expphase;
    phaseerr_nxt   = phaseerr_q;
`endif

    case (state)
      IDLE: begin
        // resync only on a clean phase 0; a pending halt keeps us parked
        if (Phases == 6'b000001 && !Halt) begin
          strobe_nxt = 6'b000001;
          state_nxt  = RUN;
        end
      end

      RUN: begin
        strobe_nxt = Phases;
        // MemEn still fires on the stalling phase; the stall only blocks what follows
        if (Phases[3] && !MemReady) begin
          state_nxt   = WAIT_MEM;
          waitcnt_nxt = 8'd1;
        end
        if (Phases[5]) begin
          if (Halt) begin
            strobe_nxt[5] = 1'b0;
            state_nxt     = HALTED;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end

      WAIT_MEM: begin
        if (Phases[3]) begin
          if (MemReady) begin
            strobe_nxt = 6'b001000;
            state_nxt  = RUN;
          end else begin
            waitcnt_nxt = waitcnt_inc[7:0];
            if (waitcnt_inc >= MAX_WAIT_C) begin
              memtimeout_nxt = 1'b1;
              state_nxt      = ERROR;
            end else begin
              strobe_nxt = 6'b001000;
            end
          end
        end
      end

      HALTED: begin
        if (Phases[0] && !Halt) begin
          strobe_nxt = 6'b000001;
          state_nxt  = RUN;
        end
      end

      ERROR: begin
        state_nxt = ERROR;
      end

      default: begin
        state_nxt = ERROR;
      end
    endcase

`ifdef PHASE_CHECK_EN
    // a sequence fault overrides whatever the state logic decided this cycle
    if (state == RUN || state == WAIT_MEM || state == HALTED) begin
      if (Phases != (6'd1 << expphase)) begin
        state_nxt      = ERROR;
        strobe_nxt     = '0;
        phaseerr_nxt   = 1'b1;
        count_nxt      = count;
        waitcnt_nxt    = waitcnt;
        memtimeout_nxt = memtimeout_q;
      end else begin
        expphase_nxt = (expphase == 3'd5) ? 3'd0 : expphase + 3'd1;
      end
    end else if (state == IDLE && state_nxt == RUN) begin
      expphase_nxt = 3'd1;
    end
`endif
  end

  assign busy_nxt = (state_nxt == RUN) || (state_nxt == WAIT_MEM);

  always_ff @(posedge inClk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      waitcnt      <= '0;
      strobe       <= '0;
      busy_q       <= 1'b0;
      memtimeout_q <= 1'b0;
      count        <= '0;
`ifdef PHASE_CHECK_EN
      expphase     <= '0;
      phaseerr_q   <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      waitcnt      <= waitcnt_nxt;
      strobe       <= strobe_nxt;
      busy_q       <= busy_nxt;
      memtimeout_q <= memtimeout_nxt;
      count        <= count_nxt;
`ifdef PHASE_CHECK_EN
      expphase     <= expphase_nxt;
      phaseerr_q   <= phaseerr_nxt;
`endif
    end
  end

  assign {PcWrEn, RegWrEn, MemEn, AluEn, RegRdEn, IrLdEn} = strobe;
  assign Busy       = busy_q;
  assign MemTimeout = memtimeout_q;
  assign InstrCount = count;
`ifdef PHASE_CHECK_EN
  assign PhaseErr   = phaseerr_q;
`else
  assign PhaseErr   = 1'b0;
`endif

endmodule

// File: tb/tb_phase_step_controller.sv
// Purpose: self-checking bench for phase_step_controller (table, directed corners, random vs model).
// Latency: expects every strobe one cycle after its phase is sampled.
// Backpressure: exercises MemReady stalls, timeout and Halt parking.
module tb_phase_step_controller;

  localparam int CNT_W_TB    = 4;
  localparam int MAX_WAIT_TB = 4;

  logic                inClk = 1'b0;
  logic                Reset = 1'b1;
  logic [5:0]          Phases = '0;
  logic                MemReady = 1'b0;
  logic                Halt = 1'b0;
  logic                IrLdEn, RegRdEn, AluEn, MemEn, RegWrEn, PcWrEn;
  logic                Busy, PhaseErr, MemTimeout;
  logic [CNT_W_TB-1:0] InstrCount;

  phase_step_controller #(.CNT_W(CNT_W_TB), .MAX_WAIT(MAX_WAIT_TB)) dut (
    .inClk(inClk), .Reset(Reset), .Phases(Phases), .MemReady(MemReady), .Halt(Halt),
    .IrLdEn(IrLdEn), .RegRdEn(RegRdEn), .AluEn(AluEn), .MemEn(MemEn),
    .RegWrEn(RegWrEn), .PcWrEn(PcWrEn), .Busy(Busy), .PhaseErr(PhaseErr),
    .MemTimeout(MemTimeout), .InstrCount(InstrCount)
  );

  always #5 inClk = ~inClk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 executing, 2 waiting on memory, 3 halted, 4 dead until reset
  int         m_mode, m_exp, m_wait, m_cnt;
  bit         m_perr, m_tmo;
  logic [5:0] m_stb;

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_wait = 0; m_cnt = 0;
    m_perr = 0; m_tmo = 0; m_stb = '0;
  endtask

  task automatic model_step(input logic [5:0] p, input bit mr, input bit h);
    int idx;
    bit bad;
    idx = -1;
    bad = 0;
    for (int i = 0; i < 6; i++) if (p == (6'd1 << i)) idx = i;
    m_stb = '0;
    if (m_mode == 0) begin
      if (p == 6'd1 && !h) begin m_stb = 6'd1; m_mode = 1; m_exp = 1; end
    end else if (m_mode != 4) begin
`ifdef PHASE_CHECK_EN
      bad = (idx != m_exp);
`endif
      if (bad) begin
        m_perr = 1; m_mode = 4;
      end else begin
        m_exp = (m_exp + 1) % 6;
        if (m_mode == 1) begin
          if (idx >= 0) m_stb = 6'd1 << idx;
          if (idx == 3 && !mr) begin m_mode = 2; m_wait = 1; end
          if (idx == 5) begin
            if (h) begin m_stb = '0; m_mode = 3; end
            else m_cnt = (m_cnt + 1) % (1 << CNT_W_TB);
          end
        end else if (m_mode == 2) begin
          if (idx == 3) begin
            if (mr) begin m_stb = 6'b001000; m_mode = 1; end
            else begin
              m_wait++;
              if (m_wait >= MAX_WAIT_TB) begin m_tmo = 1; m_mode = 4; end
              else m_stb = 6'b001000;
            end
          end
        end else begin
          if (idx == 0 && !h) begin m_stb = 6'd1; m_mode = 1; end
        end
      end
    end
  endtask

  function automatic logic [12:0] modelvec();
    logic busy;
    busy = (m_mode == 1) || (m_mode == 2);
    return {4'(m_cnt), busy, m_perr, m_tmo, m_stb};
  endfunction

  function automatic logic [12:0] outvec();
    return {InstrCount, Busy, PhaseErr, MemTimeout,
            PcWrEn, RegWrEn, MemEn, AluEn, RegRdEn, IrLdEn};
  endfunction

  function automatic logic [5:0] ph(input int i);
    return 6'd1 << i;
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge inClk);
    Reset = 1'b1; Phases = '0; MemReady = 1'b0; Halt = 1'b0;
    #1;
    chk("reset_outputs", outvec(), 13'd0);
    model_reset();
    @(negedge inClk);
    Reset = 1'b0;
  endtask

  task automatic cyc(input logic [5:0] p, input logic mr, input logic h, input string nm);
    @(negedge inClk);
    Phases = p; MemReady = mr; Halt = h;
    @(posedge inClk);
    #1;
    model_step(p, mr, h);
    chk(nm, outvec(), modelvec());
  endtask

  task automatic round(input logic mr3, input logic h5);
    for (int i = 0; i < 6; i++)
      cyc(ph(i), (i == 3) ? mr3 : 1'b1, (i == 5) ? h5 : 1'b0, "round");
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [5:0] ph;
    logic       mr;
    logic       h;
    logic [5:0] stb;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void addv(input int pi, input logic mr, input logic h,
                               input logic [5:0] stb, input logic busy, input int cnt);
    vec_t v;
    v.ph = ph(pi); v.mr = mr; v.h = h; v.stb = stb; v.busy = busy; v.cnt = 4'(cnt);
    tbl.push_back(v);
  endfunction

  initial begin
    int gp;
    int r;
    logic [5:0] p;

    // three clean instructions: strobe follows its phase, count bumps on phase 5
    for (int rr = 0; rr < 3; rr++)
      for (int i = 0; i < 6; i++)
        addv(i, 1, 0, ph(i), 1, rr + ((i == 5) ? 1 : 0));
    // fourth instruction stalls on two Phases[3] samples before memory is ready
    addv(0, 1, 0, 6'b000001, 1, 3);
    addv(1, 1, 0, 6'b000010, 1, 3);
    addv(2, 1, 0, 6'b000100, 1, 3);
    addv(3, 0, 0, 6'b001000, 1, 3);
    addv(4, 1, 0, 6'b000000, 1, 3);
    addv(5, 1, 0, 6'b000000, 1, 3);
    addv(0, 1, 0, 6'b000000, 1, 3);
    addv(1, 1, 0, 6'b000000, 1, 3);
    addv(2, 1, 0, 6'b000000, 1, 3);
    addv(3, 0, 0, 6'b001000, 1, 3);
    addv(4, 1, 0, 6'b000000, 1, 3);
    addv(5, 1, 0, 6'b000000, 1, 3);
    addv(0, 1, 0, 6'b000000, 1, 3);
    addv(1, 1, 0, 6'b000000, 1, 3);
    addv(2, 1, 0, 6'b000000, 1, 3);
    addv(3, 1, 0, 6'b001000, 1, 3);
    addv(4, 1, 0, 6'b010000, 1, 3);
    addv(5, 1, 0, 6'b100000, 1, 4);

    model_reset();
    #2;
    chk("async_reset_state", outvec(), 13'd0);
    do_reset();

    foreach (tbl[k]) begin
      @(negedge inClk);
      Phases = tbl[k].ph; MemReady = tbl[k].mr; Halt = tbl[k].h;
      @(posedge inClk);
      #1;
      model_step(tbl[k].ph, tbl[k].mr, tbl[k].h);
      chk($sformatf("table[%0d]", k), outvec(),
          {tbl[k].cnt, tbl[k].busy, 1'b0, 1'b0, tbl[k].stb});
    end

    // memory timeout: 4th consecutive not-ready Phases[3] traps with no MemEn
    do_reset();
    round(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(ph(i), 1'b1, 1'b0, "tmo_pre");
    for (int k = 1; k <= 4; k++) begin
      cyc(ph(3), 1'b0, 1'b0, "tmo_p3");
      if (k < 4) for (int i = 4; i < 9; i++) cyc(ph(i % 6), 1'b1, 1'b0, "tmo_wait");
    end
    chk("timeout_flags", outvec(), {4'd1, 1'b0, 1'b0, 1'b1, 6'b000000});
    for (int i = 4; i < 16; i++) begin
      cyc(ph(i % 6), 1'b1, 1'b0, "tmo_dead");
      chk("timeout_dead_strobes", {7'd0, PcWrEn, RegWrEn, MemEn, AluEn, RegRdEn, IrLdEn}, 13'd0);
    end

    // halt at phase 5, held through one phase 0, released before the next
    do_reset();
    round(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(ph(i), 1'b1, 1'b0, "halt_pre");
    cyc(ph(5), 1'b1, 1'b1, "halt_enter");
    chk("halt_pcwr_suppressed", outvec(), {4'd1, 1'b0, 1'b0, 1'b0, 6'b000000});
    cyc(ph(0), 1'b1, 1'b1, "halt_hold");
    chk("halt_hold_quiet", outvec(), {4'd1, 1'b0, 1'b0, 1'b0, 6'b000000});
    for (int i = 1; i < 6; i++) cyc(ph(i), 1'b1, 1'b0, "halted");
    cyc(ph(0), 1'b1, 1'b0, "halt_exit");
    chk("halt_exit_irld", outvec(), {4'd1, 1'b1, 1'b0, 1'b0, 6'b000001});
    for (int i = 1; i < 6; i++) cyc(ph(i), 1'b1, 1'b0, "halt_post");
    chk("halt_resume_count", {9'd0, InstrCount}, 13'd2);

    // out-of-sequence phase: ALU phase where register read is expected
    do_reset();
    cyc(ph(0), 1'b1, 1'b0, "perr_p0");
    cyc(6'b000100, 1'b1, 1'b0, "perr_inject");
`ifdef PHASE_CHECK_EN
    chk("perr_trap", outvec(), {4'd0, 1'b0, 1'b1, 1'b0, 6'b000000});
    for (int i = 3; i < 12; i++) cyc(ph(i % 6), 1'b1, 1'b0, "perr_dead");
    chk("perr_sticky", outvec(), {4'd0, 1'b0, 1'b1, 1'b0, 6'b000000});
`else
    chk("perr_unchecked", outvec(), {4'd0, 1'b1, 1'b0, 1'b0, 6'b000100});
`endif

    // counter wrap after 17 instructions, then reset mid-round
    do_reset();
    for (int n = 0; n < 17; n++) round(1'b1, 1'b0);
    chk("count_wrap", {9'd0, InstrCount}, 13'd1);
    for (int i = 0; i < 3; i++) cyc(ph(i), 1'b1, 1'b0, "wrap_next");
    chk("pre_reset_alu", {12'd0, AluEn}, 13'd1);
    #2 Reset = 1'b1;
    #1;
    chk("midround_reset_immediate", outvec(), 13'd0);
    model_reset();
    @(negedge inClk);
    Reset = 1'b0;
    for (int i = 3; i < 6; i++) cyc(ph(i), 1'b1, 1'b0, "resync_ignore");
    chk("resync_quiet", outvec(), 13'd0);
    cyc(ph(0), 1'b1, 1'b0, "resync_p0");
    chk("resync_irld", outvec(), {4'd0, 1'b1, 1'b0, 1'b0, 6'b000001});

    // randomized traffic against the model
    do_reset();
    gp = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        gp = 0;
      end
      r = $urandom_range(0, 99);
      if (r < 96) begin
        p = ph(gp); gp = (gp + 1) % 6;
      end else if (r < 97) begin
        p = '0;
      end else if (r < 99) begin
        gp = $urandom_range(0, 5);
        p = ph(gp); gp = (gp + 1) % 6;
      end else begin
`ifdef PHASE_CHECK_EN
        p = ph(gp) | ph((gp + 2) % 6);
`else
        p = ph(gp);
`endif
        gp = (gp + 1) % 6;
      end
      cyc(p, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/phase_step_controller.md
Name: phase_step_controller

Overview:
- Sits directly downstream of the six-phase clock generator in the multi-cycle datapath.
- Consumes the one-hot Phases bus and turns it into registered per-stage enable strobes: IR load, register read, ALU, memory, register write, PC write.
- Adds a memory-ready stall with timeout, a halt request, phase-sequence integrity checking, and a retired-instruction counter.

Parameters:
- CNT_W, 16: width of InstrCount.
- MAX_WAIT, 15: max number of Phases[3] occurrences spent in WAIT_MEM before timeout; legal range 1..255.

Ports:
- inClk  input  1  system clock, same clock as the phase generator.
- Reset  input  1  async active-high reset.
- Phases  input  6  one-hot phase bus; nominal order 0,1,2,3,4,5,0...
- MemReady  input  1  memory access complete, sampled only when Phases[3]=1.
- Halt  input  1  halt request, sampled at Phases[5] (enter) and Phases[0] (exit).
- IrLdEn  output  1  instruction register load strobe.
- RegRdEn  output  1  register file read strobe.
- AluEn  output  1  ALU strobe.
- MemEn  output  1  memory access strobe.
- RegWrEn  output  1  register write-back strobe.
- PcWrEn  output  1  PC update strobe.
- Busy  output  1  high in RUN or WAIT_MEM.
- PhaseErr  output  1  sticky phase-sequence error.
- MemTimeout  output  1  sticky memory wait timeout.
- InstrCount  output  CNT_W  retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port inClk, reset port Reset.
- Reset (async, immediate): all strobes 0, Busy 0, PhaseErr 0, MemTimeout 0, InstrCount 0, WaitCnt 0, state IDLE.
- All outputs are registered. A strobe is high for exactly the one cycle after the posedge at which its phase was sampled (latency 1).
- Phase-to-strobe map: [0]->IrLdEn, [1]->RegRdEn, [2]->AluEn, [3]->MemEn, [4]->RegWrEn, [5]->PcWrEn.
- ExpPhase register: index of the next expected phase; advances 5->0.
- IDLE:
  - Ignore Phases until Phases==6'b000001.
  - Then emit IrLdEn, set ExpPhase=1, go RUN.
  - If Halt=1 at that edge, stay IDLE instead.
- RUN: each cycle, emit the mapped strobe for the current phase and advance ExpPhase.
  - At Phases[3] with MemReady=0: MemEn is still emitted; go WAIT_MEM, WaitCnt=1.
  - At Phases[5] with Halt=0: PcWrEn emitted, InstrCount+1.
  - At Phases[5] with Halt=1: PcWrEn suppressed, InstrCount unchanged, go HALTED.
- WAIT_MEM:
  - Phase tracking continues; only MemEn is emitted, at each Phases[3].
  - Phases[4],[5],[0],[1],[2] produce no strobe.
  - At Phases[3] with MemReady=1: emit MemEn, return to RUN. RegWrEn and PcWrEn then follow normally.
  - At Phases[3] with MemReady=0: WaitCnt+1. If WaitCnt reaches MAX_WAIT, set MemTimeout and go ERROR with no MemEn emitted.
- HALTED:
  - No strobes; phase tracking continues.
  - At Phases[0] with Halt=0: emit IrLdEn, go RUN.
- ERROR: all strobes 0, Busy 0; held until Reset.
- Simultaneous events:
  - Phase error beats all other conditions on the same edge.
  - MemReady and Halt cannot collide, since they are sampled at different phases.
- Reset mid-instruction aborts without any further strobe. Counter wrap from 2^CNT_W-1 goes to 0 with no flag.

Optional Feature:
- Macro PHASE_CHECK_EN.
- Defined: in RUN, WAIT_MEM and HALTED, any cycle where Phases != one-hot(ExpPhase) (including all-zero or multi-hot) sets PhaseErr and goes to ERROR. No strobe is emitted for that cycle.
- Undefined: no comparison. PhaseErr is tied to 0; ERROR is reachable only via MemTimeout. Strobes decode from Phases directly with no sequence tracking beyond the state machine.

Test Plan:
- Reset pulse, then a clean phase rotation with MemReady=1 and Halt=0 for 3 rounds -> strobes one cycle after each phase in order IrLd,RegRd,Alu,Mem,RegWr,PcWr; InstrCount=3; Busy=1 from cycle after first Phases[0].
- MemReady=0 for 2 Phases[3] occurrences, then 1 -> MemEn pulses 3 times, no RegWrEn/PcWrEn during the wait; then RegWrEn and PcWrEn once; InstrCount +1.
- MAX_WAIT=4, MemReady held 0 -> MemTimeout=1 on the 4th Phases[3] edge; state ERROR; all strobes 0 until Reset.
- Halt=1 at Phases[5], released before a later Phases[0] -> PcWrEn suppressed, InstrCount unchanged, no strobes while halted, IrLdEn on the next Phases[0] after release.
- PHASE_CHECK_EN defined, inject Phases=6'b000100 where 6'b000010 is expected -> PhaseErr=1 next cycle, no AluEn, strobes stay 0; PhaseErr clears only on Reset.
- CNT_W=4, run 17 instructions -> InstrCount wraps to 1; assert Reset mid-round at Phases[2] -> all outputs 0 immediately, block resyncs on the next Phases[0].
